// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined immediate generator: format codes,
// base opcodes and skid-buffer occupancy states.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder (I/S/B/U/J, optional CSR zimm).
// Define IMM_GEN_ZIMM_EN to decode CSR*I immediates as FMT_Z.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic            illegal_o
);

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic signed [31:0] raw;

    always_comb begin
        opc       = inst_i[6:0];
        f3        = inst_i[14:12];
        raw       = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR: begin
                fmt_o = FMT_I;
                raw   = {{20{inst_i[31]}}, inst_i[31:20]};
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                raw   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o = FMT_B;
                raw   = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                         inst_i[30:25], inst_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = FMT_U;
                raw   = {inst_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o = FMT_J;
                raw   = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                         inst_i[20], inst_i[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
`ifdef IMM_GEN_ZIMM_EN
                if (f3[2]) begin
                    fmt_o = FMT_Z;
                    raw   = {27'b0, inst_i[19:15]};
                end else begin
                    fmt_o = FMT_I;
                    raw   = {{20{inst_i[31]}}, inst_i[31:20]};
                end
`else
                fmt_o = FMT_I;
                raw   = {{20{inst_i[31]}}, inst_i[31:20]};
`endif
            end
            // also catches every compressed encoding (inst[1:0] != 2'b11)
            default: illegal_o = 1'b1;
        endcase
        if (XLEN == 32) begin
            if (opc == OPC_OP_IMM && (f3 == 3'b001 || f3 == 3'b101)
                && inst_i[25])
                illegal_o = 1'b1;
            if (opc == OPC_OP_IMM32)
                illegal_o = 1'b1;
        end
        imm_o = XLEN'(raw);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode on input, 2-entry skid buffer.
// Optional CSR zimm decode enabled by defining IMM_GEN_ZIMM_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_ill;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst_i    (in_inst),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_ill)
    );

    state_e           state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [XLEN-1:0]  m_imm_q, m_imm_d, s_imm_q, s_imm_d;
    fmt_e             m_fmt_q, m_fmt_d, s_fmt_q, s_fmt_d;
    logic             m_ill_q, m_ill_d, s_ill_q, s_ill_d;
    logic [TAG_W-1:0] m_tag_q, m_tag_d, s_tag_q, s_tag_d;
    logic             accept, drain;

    assign accept = in_valid & rdy_q;
    assign drain  = (state_q != EMPTY) & out_ready;

    always_comb begin
        state_d = state_q;
        m_imm_d = m_imm_q;
        m_fmt_d = m_fmt_q;
        m_ill_d = m_ill_q;
        m_tag_d = m_tag_q;
        s_imm_d = s_imm_q;
        s_fmt_d = s_fmt_q;
        s_ill_d = s_ill_q;
        s_tag_d = s_tag_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    m_imm_d = dec_imm;
                    m_fmt_d = dec_fmt;
                    m_ill_d = dec_ill;
                    m_tag_d = in_tag;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    m_imm_d = dec_imm;
                    m_fmt_d = dec_fmt;
                    m_ill_d = dec_ill;
                    m_tag_d = in_tag;
                end else if (accept) begin
                    // M is stalled; park the newcomer in S
                    s_imm_d = dec_imm;
                    s_fmt_d = dec_fmt;
                    s_ill_d = dec_ill;
                    s_tag_d = in_tag;
                    state_d = TWO;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    m_imm_d = s_imm_q;
                    m_fmt_d = s_fmt_q;
                    m_ill_d = s_ill_q;
                    m_tag_d = s_tag_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        rdy_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
            m_imm_q <= '0;
            m_fmt_q <= FMT_NONE;
            m_ill_q <= 1'b0;
            m_tag_q <= '0;
            s_imm_q <= '0;
            s_fmt_q <= FMT_NONE;
            s_ill_q <= 1'b0;
            s_tag_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            m_imm_q <= m_imm_d;
            m_fmt_q <= m_fmt_d;
            m_ill_q <= m_ill_d;
            m_tag_q <= m_tag_d;
            s_imm_q <= s_imm_d;
            s_fmt_q <= s_fmt_d;
            s_ill_q <= s_ill_d;
            s_tag_q <= s_tag_d;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = (state_q != EMPTY);
    assign out_imm     = m_imm_q;
    assign out_fmt     = m_fmt_q;
    assign out_illegal = m_ill_q;
    assign out_tag     = m_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: randomized and directed stimulus,
// expectations from an arithmetic reference decoder.
module tb_imm_gen_pipe;

    localparam int XLEN  = 64;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [3:0]  tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_inst = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    int   edges = 0;
    int   rdy_mode = 0;
    logic rdy_force = 1'b1;

    function automatic exp_t ref_decode(input logic [31:0] w,
                                        input logic [3:0] t);
        exp_t    r;
        longint  v;
        logic [6:0] op;
        logic [2:0] f3;
        op    = w[6:0];
        f3    = w[14:12];
        v     = 0;
        r.fmt = 3'd0;
        r.ill = 1'b0;
        r.tag = t;
        case (op)
            7'h03, 7'h13, 7'h1B, 7'h67: begin
                r.fmt = 3'd1; v = w[31:20];
                if (w[31]) v = v - 4096;
            end
            7'h23: begin
                r.fmt = 3'd2; v = {w[31:25], w[11:7]};
                if (w[31]) v = v - 4096;
            end
            7'h63: begin
                r.fmt = 3'd3; v = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                if (w[31]) v = v - 8192;
            end
            7'h37, 7'h17: begin
                r.fmt = 3'd4; v = longint'(w[31:12]) * 4096;
                if (w[31]) v = v - 64'sh1_0000_0000;
            end
            7'h6F: begin
                r.fmt = 3'd5;
                v = {w[31], w[19:12], w[20], w[30:21], 1'b0};
                if (w[31]) v = v - (64'sd1 << 21);
            end
            7'h73: begin
`ifdef IMM_GEN_ZIMM_EN
                if (f3[2]) begin
                    r.fmt = 3'd6; v = w[19:15];
                end else begin
                    r.fmt = 3'd1; v = w[31:20];
                    if (w[31]) v = v - 4096;
                end
`else
                r.fmt = 3'd1; v = w[31:20];
                if (w[31]) v = v - 4096;
`endif
            end
            default: r.ill = 1'b1;
        endcase
        if (XLEN == 32) begin
            if (op == 7'h13 && (f3 == 3'b001 || f3 == 3'b101) && w[25])
                r.ill = 1'b1;
            if (op == 7'h1B) r.ill = 1'b1;
            v = v & 64'hFFFF_FFFF;
        end
        r.imm = v;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) edges = 0;
        else if (edges < 2) edges++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = rdy_force;
    end

    // monitor: occupancy checks, then pop/compare, then push accepted
    initial forever begin
        exp_t e;
        exp_t x;
        @(negedge clk);
        if (rst) begin
            sb.delete();
        end else begin
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            chk("in_ready", 64'(in_ready),
                64'((edges >= 1) && (sb.size() < 2)));
            if (out_valid && sb.size() != 0) begin
                e = sb[0];
                chk("imm", 64'(out_imm), e.imm);
                chk("fmt", 64'(out_fmt), 64'(e.fmt));
                chk("illegal", 64'(out_illegal), 64'(e.ill));
                chk("tag", 64'(out_tag), 64'(e.tag));
                if (out_ready) void'(sb.pop_front());
            end
            if (in_valid && in_ready) begin
                x = ref_decode(in_inst, in_tag);
                sb.push_back(x);
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic [3:0] t);
        in_inst  = w;
        in_tag   = t;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: tag %0d never accepted", t);
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_outs();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_fmt", 64'(out_fmt), 64'd0);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
    endtask

    logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h73, 7'h0B, 7'h33};

    initial begin
        logic [31:0] w;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        rdy_mode = 1; rdy_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(32'hFF813083, 4'd1);
        send(32'h00113823, 4'd2);
        send(32'hFE000EE3, 4'd3);
        send(32'h800000B7, 4'd4);
        send(32'h0000000B, 4'd5);
        send(32'h0000D073, 4'd6);
        send(32'h00000013, 4'd7);
        send(32'h00000002, 4'd8);
        repeat (4) @(posedge clk);
        #1;

        rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fork
            begin
                send(32'h00100093, 4'd1);
                send(32'h00200093, 4'd2);
                send(32'h00300093, 4'd3);
            end
            begin
                repeat (8) @(negedge clk);
                rdy_force = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        rdy_mode = 0;
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 11)];
            send(w, 4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        rdy_mode = 1; rdy_force = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(32'h12345037, 4'd9);
        send(32'h00C000EF, 4'd10);
        #2 rst = 1'b1;
        #1;
        chk_reset_outs();
        @(posedge clk);
        #3 rst = 1'b0;
        rdy_force = 1'b1;
        @(posedge clk);
        #1;
        send(32'hFFF00067, 4'd11);

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the core's combinational immediate generator. It covers every RV base immediate format (I/S/B/U/J) and flags unsupported opcodes. A valid/ready handshake with a 2-entry skid buffer lets it sit between fetch and decode/ALU-operand muxing without combinational ready paths. Each instruction carries a tag through the block for re-association downstream.

Parameters:
XLEN, 64, output immediate width; legal values 32 or 64.
TAG_W, 4, width of the sideband tag carried with each instruction.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream holds a valid instruction
in_ready  output  1  block can accept; registered, never depends combinationally on out_ready
in_inst  input  32  raw 32-bit instruction word
in_tag  input  TAG_W  sideband tag
out_valid  output  1  out_imm/out_fmt/out_illegal/out_tag are valid
out_ready  input  1  downstream accepts
out_imm  output  XLEN  sign- or zero-extended immediate
out_fmt  output  3  format code (see package)
out_illegal  output  1  opcode has no immediate format, or illegal shamt
out_tag  output  TAG_W  tag of the presented instruction

Behaviour:
- Reset (async, rst=1): state EMPTY; out_valid=0, in_ready=0 while rst high, in_ready=1 first cycle after release; out_imm/out_tag=0, out_fmt=FMT_NONE, out_illegal=0.
- Transfer on valid&&ready at a rising edge. Latency: accepted instruction appears on outputs the next cycle. Throughput: 1/cycle while out_ready=1.
- Storage: main register M (drives outputs), skid register S. States: EMPTY (none), ONE (M full), TWO (M and S full).
- Transitions: EMPTY+accept->ONE. ONE+accept only->TWO when out_ready=0; ONE+accept+drain->ONE (M reloaded). ONE+drain only->EMPTY. TWO+drain->ONE (S moves to M). TWO never accepts.
- in_ready = (state != TWO), registered.
- Outputs are stable while out_valid=1 and out_ready=0. Strict FIFO order.
- Decode (on in_inst, result stored in M/S, not recomputed at output):
  - opcode 0000011, 0010011, 0011011, 1100111 -> FMT_I, sext(inst[31:20]).
  - 0100011 -> FMT_S, sext({inst[31:25],inst[11:7]}).
  - 1100011 -> FMT_B, sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 0110111, 0010111 -> FMT_U, sext({inst[31:12],12'b0}).
  - 1101111 -> FMT_J, sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - 1110011 -> FMT_I, sext(inst[31:20]).
  - Any other opcode -> FMT_NONE, imm=0, illegal=1.
- sext is to XLEN. In XLEN=32, opcode 0010011 with funct3 001/101 and inst[25]=1 -> illegal=1, imm still produced. In XLEN=32, opcode 0011011 -> illegal=1.
- Instructions with inst[1:0]!=2'b11 -> FMT_NONE, illegal=1.

Optional Feature:
IMM_GEN_ZIMM_EN: when defined, SYSTEM opcode with funct3[2]=1 (CSRRWI/SI/CI) yields FMT_Z, imm = zero-extended inst[19:15]. Without it, these produce FMT_I sext(inst[31:20]), and FMT_Z is never emitted.

Decomposition:
- imm_gen_pkg: format codes FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_Z=6; opcode localparams; state encoding EMPTY/ONE/TWO.
- Sub-module imm_decode (combinational, parameter XLEN): inst -> {imm, fmt, illegal}. imm_gen_pipe instantiates it on the input side, followed by the skid buffer.

Test Plan:
- XLEN=64, in_inst=0xFF813083 (ld x1,-8(x2)), out_ready=1 -> next cycle out_imm=0xFFFFFFFFFFFFFFF8, fmt=FMT_I, illegal=0.
- in_inst=0x00113823 (sd x1,16(x2)) then 0xFE000EE3 (beq x0,x0,-4), back-to-back -> imm=0x10 FMT_S, then imm=0xFFFFFFFFFFFFFFFC FMT_B, on consecutive cycles.
- in_inst=0x800000B7 (lui x1,0x80000) -> XLEN=64: 0xFFFFFFFF80000000; XLEN=32: 0x80000000; fmt=FMT_U.
- out_ready=0, present tags 1,2,3 with in_valid=1 -> tags 1,2 accepted, in_ready=0 after second, tag 3 held; then out_ready=1 -> out_tag sequence 1,2,3, outputs stable while stalled.
- in_inst=0x0000000B (custom-0) -> FMT_NONE, imm=0, illegal=1; with IMM_GEN_ZIMM_EN, 0x0000D073 (csrrwi x0,0,1) -> FMT_Z, imm=1.
- Assert rst in TWO state mid-stream -> out_valid=0 immediately (async), in_ready=1 one cycle after release, no stale tag emitted.
